// File: rtl/jam_pkg.sv
// jam_pkg
// Shared definitions for the job-assignment engine: the FSM state type,
// search-mode encodings, the largest supported worker count, and the
// "is this sum better than the current best" helper used by the compare
// stage. No ports; imported by jam_gen and jam_perm_next.

package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    CMP,
    NEXT,
    DONE
  } jam_state_e;

  localparam int MAX_N = 8;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Sums are compared at a fixed width so one helper serves every SUM_W.
  localparam int CMP_W = 32;

  // Strict improvement test: smaller wins when minimising, larger when
  // maximising. Equal sums are never "better"; the caller counts ties.
  function automatic logic better(input logic [CMP_W-1:0] sum,
                                  input logic [CMP_W-1:0] best,
                                  input logic             mode);
    if (mode == MODE_MAX) begin
      return sum > best;
    end
    return sum < best;
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// jam_perm_next
// Holds the current worker->job permutation and steps it to its
// lexicographic successor on request.
// Ports:
//   CLK, RST       clock and synchronous active-high reset (perm -> identity)
//   load_identity  one-cycle request to restart from the identity permutation
//   step_req       held high while the owner waits for the next permutation
//   step_done      one-cycle pulse: perm_o now holds the successor
//   is_last        current permutation is strictly descending (final one)
//   perm_o         current permutation, entry i is the job of worker i

module jam_perm_next
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load_identity,
  input  logic                    step_req,
  output logic                    step_done,
  output logic                    is_last,
  output logic [N-1:0][IDX_W-1:0] perm_o
);

  // Loop bound clamped to the largest supported size so the combinational
  // successor network never grows past what the design was built for.
  localparam int NP = (N > MAX_N) ? MAX_N : N;

  logic [N-1:0][IDX_W-1:0] perm_q;
  logic [N-1:0][IDX_W-1:0] permNext_d;
  logic [N-1:0][IDX_W-1:0] swapped;
  logic                    stepDone_q;
  int                      pivotIdx;
  int                      succIdx;

  // Successor in one combinational pass: find the pivot (rightmost ascent),
  // swap it with the rightmost larger entry, then mirror the tail. The tail
  // right of the pivot is descending, so mirroring it makes it ascending.
  always_comb begin
    pivotIdx   = 0;
    succIdx    = 0;
    swapped    = perm_q;
    permNext_d = perm_q;
    for (int i = 0; i < NP - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        pivotIdx = i;
      end
    end
    for (int j = 0; j < NP; j++) begin
      if ((j > pivotIdx) && (perm_q[j] > perm_q[pivotIdx])) begin
        succIdx = j;
      end
    end
    swapped[pivotIdx] = perm_q[succIdx];
    swapped[succIdx]  = perm_q[pivotIdx];
    for (int k = 0; k < NP; k++) begin
      if (k <= pivotIdx) begin
        permNext_d[k] = swapped[k];
      end else begin
        permNext_d[k] = swapped[NP + pivotIdx - k];
      end
    end
  end

  // The last permutation has no ascent anywhere.
  always_comb begin
    is_last = 1'b1;
    for (int i = 0; i < NP - 1; i++) begin
      if (perm_q[i] <= perm_q[i+1]) begin
        is_last = 1'b0;
      end
    end
  end

  // A step takes two cycles: the first writes the successor, the second
  // raises step_done so the owner reads the already-updated register.
  always_ff @(posedge CLK) begin
    if (RST || load_identity) begin
      for (int i = 0; i < N; i++) begin
        perm_q[i] <= IDX_W'(i);
      end
      stepDone_q <= 1'b0;
    end else if (step_req && !stepDone_q) begin
      perm_q     <= permNext_d;
      stepDone_q <= 1'b1;
    end else begin
      stepDone_q <= 1'b0;
    end
  end

  assign step_done = stepDone_q;
  assign perm_o    = perm_q;

endmodule

// File: rtl/jam_gen.sv
// jam_gen
// Exhaustive job-assignment search: walks all N! worker->job permutations,
// sums each one's costs from an external combinational ROM, and reports the
// best total (minimum or maximum) and how many permutations reach it.
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   Start       one-cycle request to begin a search (from IDLE or DONE)
//   Mode        0 = minimise, 1 = maximise; captured together with Start
//   W, J        registered worker / job index presented to the cost ROM
//   Cost        ROM data for the current W/J, valid in the same cycle
//   BestCost    best total cost found (meaningful while Valid is high)
//   MatchCount  permutations equal to BestCost, saturating
//   Valid       result ready; held until the next Start or RST

module jam_gen
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 4,
  parameter int IDX_W  = $clog2(N),
  parameter int SUM_W  = COST_W + $clog2(N) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Mode,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  BestCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);

  jam_state_e              state_q;
  logic                    mode_q;
  logic [IDX_W-1:0]        kIdx_q;
  logic [SUM_W-1:0]        accSum_q;
  logic                    firstPerm_q;
  logic [IDX_W-1:0]        wIdx_q;
  logic [IDX_W-1:0]        jIdx_q;
  logic [SUM_W-1:0]        bestCost_q;
  logic [CNT_W-1:0]        matchCount_q;
  logic                    valid_q;

  logic [IDX_W-1:0]        kNext_d;
  logic [SUM_W-1:0]        accNext_d;
  logic                    isBetter;
  logic                    loadIdentity;
  logic                    stepReq;
  logic                    stepDone;
  logic                    isLast;
  logic [N-1:0][IDX_W-1:0] perm;

  assign kNext_d   = kIdx_q + IDX_W'(1);
  assign accNext_d = accSum_q + SUM_W'(Cost);
  assign isBetter  = better(CMP_W'(accSum_q), CMP_W'(bestCost_q), mode_q);

  // A new search may only be launched from IDLE or DONE; Start elsewhere
  // must not disturb the permutation being evaluated.
  assign loadIdentity = ((state_q == IDLE) || (state_q == DONE)) && Start;
  assign stepReq      = (state_q == NEXT);

  jam_perm_next #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_perm (
    .CLK           (CLK),
    .RST           (RST),
    .load_identity (loadIdentity),
    .step_req      (stepReq),
    .step_done     (stepDone),
    .is_last       (isLast),
    .perm_o        (perm)
  );

  // Main sequencer. W/J are registered one cycle ahead: the cycle in which
  // CALC sees index k already presents W=k, J=perm[k], so the Cost arriving
  // at the closing edge belongs to that pair. J for a fresh search is forced
  // to 0 because the permutation register reloads on that same edge. W/J
  // simply hold their last values through CMP and NEXT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      mode_q       <= MODE_MIN;
      kIdx_q       <= '0;
      accSum_q     <= '0;
      firstPerm_q  <= 1'b0;
      wIdx_q       <= '0;
      jIdx_q       <= '0;
      bestCost_q   <= '0;
      matchCount_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q     <= CALC;
            mode_q      <= Mode;
            kIdx_q      <= '0;
            accSum_q    <= '0;
            firstPerm_q <= 1'b1;
            wIdx_q      <= '0;
            jIdx_q      <= '0;
            valid_q     <= 1'b0;
          end
        end
        CALC: begin
          accSum_q <= accNext_d;
          if (kIdx_q == IDX_W'(N - 1)) begin
            state_q <= CMP;
          end else begin
            kIdx_q <= kNext_d;
            wIdx_q <= kNext_d;
            jIdx_q <= perm[kNext_d];
          end
        end
        CMP: begin
          firstPerm_q <= 1'b0;
          if (firstPerm_q || isBetter) begin
            bestCost_q   <= accSum_q;
            matchCount_q <= CNT_W'(1);
          end else if (accSum_q == bestCost_q) begin
            if (matchCount_q != {CNT_W{1'b1}}) begin
              matchCount_q <= matchCount_q + CNT_W'(1);
            end
          end
          if (isLast) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (stepDone) begin
            state_q  <= CALC;
            accSum_q <= '0;
            kIdx_q   <= '0;
            wIdx_q   <= '0;
            jIdx_q   <= perm[0];
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign W          = wIdx_q;
  assign J          = jIdx_q;
  assign BestCost   = bestCost_q;
  assign MatchCount = matchCount_q;
  assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_gen.sv
// tb_jam_gen
// Directed bench for jam_gen. Four instances cover the parameter corners:
// N=4 with CNT_W=4 and CNT_W=5, N=2, and N=6. Each drives its own cost ROM
// from small combinational tables whose optimum is worked out by hand.

module tb_jam_gen;

  logic CLK;
  logic RST;
  logic tableSel;

  logic       start4,  mode4,  start4w, mode4w;
  logic       start2,  mode2,  start6,  mode6;

  logic [1:0] w4,  j4;   logic [6:0] cost4;  logic [9:0]  best4;  logic [3:0] cnt4;  logic valid4;
  logic [1:0] w4w, j4w;  logic [6:0] cost4w; logic [9:0]  best4w; logic [4:0] cnt4w; logic valid4w;
  logic       w2,  j2;   logic [6:0] cost2;  logic [8:0]  best2;  logic [3:0] cnt2;  logic valid2;
  logic [2:0] w6,  j6;   logic [6:0] cost6;  logic [10:0] best6;  logic [3:0] cnt6;  logic valid6;

  int checkCount;
  int passCount;

  // Cost tables: tableSel=0 -> 1 on the diagonal, 10 elsewhere; 1 -> all 5.
  // N=2 uses [[1,2],[2,1]]; N=6 uses cost = w*j.
  assign cost4  = tableSel ? 7'd5 : ((w4 == j4) ? 7'd1 : 7'd10);
  assign cost4w = tableSel ? 7'd5 : ((w4w == j4w) ? 7'd1 : 7'd10);
  assign cost2  = (w2 == j2) ? 7'd1 : 7'd2;
  assign cost6  = 7'(w6) * 7'(j6);

  jam_gen #(.N(4), .COST_W(7), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .Start(start4), .Mode(mode4), .W(w4), .J(j4),
    .Cost(cost4), .BestCost(best4), .MatchCount(cnt4), .Valid(valid4));

  jam_gen #(.N(4), .COST_W(7), .CNT_W(5)) dut4w (
    .CLK(CLK), .RST(RST), .Start(start4w), .Mode(mode4w), .W(w4w), .J(j4w),
    .Cost(cost4w), .BestCost(best4w), .MatchCount(cnt4w), .Valid(valid4w));

  jam_gen #(.N(2), .COST_W(7), .CNT_W(4)) dut2 (
    .CLK(CLK), .RST(RST), .Start(start2), .Mode(mode2), .W(w2), .J(j2),
    .Cost(cost2), .BestCost(best2), .MatchCount(cnt2), .Valid(valid2));

  jam_gen #(.N(6), .COST_W(7), .CNT_W(4)) dut6 (
    .CLK(CLK), .RST(RST), .Start(start6), .Mode(mode6), .W(w6), .J(j6),
    .Cost(cost6), .BestCost(best6), .MatchCount(cnt6), .Valid(valid6));

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulses Start for one cycle on every instance selected in mask
  // (bit0 dut4, bit1 dut4w, bit2 dut2, bit3 dut6), with the given Mode.
  task automatic applyStimulus(input logic [3:0] mask, input logic mode);
    @(negedge CLK);
    if (mask[0]) begin mode4  = mode; start4  = 1'b1; end
    if (mask[1]) begin mode4w = mode; start4w = 1'b1; end
    if (mask[2]) begin mode2  = mode; start2  = 1'b1; end
    if (mask[3]) begin mode6  = mode; start6  = 1'b1; end
    @(negedge CLK);
    start4  = 1'b0;
    start4w = 1'b0;
    start2  = 1'b0;
    start6  = 1'b0;
  endtask

  function automatic logic getValid(input int idx);
    case (idx)
      0:       return valid4;
      1:       return valid4w;
      2:       return valid2;
      default: return valid6;
    endcase
  endfunction

  // Bounded wait for Valid; an expired bound shows up as a failed check.
  task automatic waitValid(input int idx, input int bound, input string tag);
    int cycles = 0;
    while (!getValid(idx) && (cycles < bound)) begin
      @(negedge CLK);
      cycles++;
    end
    checkOutput(tag, 32'(getValid(idx)), 32'd1);
  endtask

  initial begin
    logic [1:0] trace[$];
    logic [1:0] pair;
    int         cycles;

    checkCount = 0;
    passCount  = 0;
    tableSel   = 1'b0;
    start4 = 1'b0; mode4 = 1'b0; start4w = 1'b0; mode4w = 1'b0;
    start2 = 1'b0; mode2 = 1'b0; start6  = 1'b0; mode6  = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    checkOutput("rst_valid", 32'(valid4), 32'd0);
    checkOutput("rst_best",  32'(best4),  32'd0);
    checkOutput("rst_count", 32'(cnt4),   32'd0);
    checkOutput("rst_w",     32'(w4),     32'd0);
    checkOutput("rst_j",     32'(j4),     32'd0);

    // N=4 diagonal table, minimise: identity is the unique best (4 x 1)
    $display("[TB] N=4 diagonal table, minimise");
    applyStimulus(4'b0001, 1'b0);
    waitValid(0, 218, "n4_min_valid");
    checkOutput("n4_min_best",  32'(best4), 32'd4);
    checkOutput("n4_min_count", 32'(cnt4),  32'd1);
    repeat (5) @(negedge CLK);
    checkOutput("n4_valid_held", 32'(valid4), 32'd1);

    // Same table, maximise: the 9 derangements each sum to 40
    $display("[TB] N=4 diagonal table, maximise");
    applyStimulus(4'b0001, 1'b1);
    checkOutput("n4_valid_drop", 32'(valid4), 32'd0);
    waitValid(0, 218, "n4_max_valid");
    checkOutput("n4_max_best",  32'(best4), 32'd40);
    checkOutput("n4_max_count", 32'(cnt4),  32'd9);

    // All costs 5: 24 ties, 4-bit counter saturates at 15, 5-bit holds 24
    $display("[TB] N=4 uniform table, two counter widths");
    tableSel = 1'b1;
    applyStimulus(4'b0011, 1'b0);
    waitValid(0, 218, "n4_flat_valid");
    waitValid(1, 218, "n4w_flat_valid");
    checkOutput("n4_flat_best",   32'(best4),  32'd20);
    checkOutput("n4_flat_sat",    32'(cnt4),   32'd15);
    checkOutput("n4w_flat_best",  32'(best4w), 32'd20);
    checkOutput("n4w_flat_count", 32'(cnt4w),  32'd24);

    // N=2: W/J walk and Valid latency (W/J hold between CALC phases)
    $display("[TB] N=2 trace");
    applyStimulus(4'b0100, 1'b0);
    cycles = 0;
    while (!valid2 && (cycles < 12)) begin
      pair = {w2, j2};
      if ((trace.size() == 0) || (trace[trace.size()-1] != pair)) begin
        trace.push_back(pair);
      end
      @(negedge CLK);
      cycles++;
    end
    checkOutput("n2_valid_in_12", 32'(valid2), 32'd1);
    checkOutput("n2_trace_len", 32'(trace.size()), 32'd4);
    checkOutput("n2_trace0", (trace.size() > 0) ? 32'(trace[0]) : 32'hFFFF, 32'd0);
    checkOutput("n2_trace1", (trace.size() > 1) ? 32'(trace[1]) : 32'hFFFF, 32'd3);
    checkOutput("n2_trace2", (trace.size() > 2) ? 32'(trace[2]) : 32'hFFFF, 32'd1);
    checkOutput("n2_trace3", (trace.size() > 3) ? 32'(trace[3]) : 32'hFFFF, 32'd2);
    checkOutput("n2_best",  32'(best2), 32'd2);
    checkOutput("n2_count", 32'(cnt2),  32'd1);

    // N=6, cost w*j: reversed pairing is the unique minimum (20); a Start
    // pulse in mode 1 part-way through must be ignored.
    $display("[TB] N=6 product table, minimise with stray Start");
    applyStimulus(4'b1000, 1'b0);
    repeat (300) @(negedge CLK);
    applyStimulus(4'b1000, 1'b1);
    waitValid(3, 9362, "n6_min_valid");
    checkOutput("n6_min_best",  32'(best6), 32'd20);
    checkOutput("n6_min_count", 32'(cnt6),  32'd1);

    // Identity pairing is the unique maximum: 0+1+4+9+16+25
    $display("[TB] N=6 product table, maximise");
    applyStimulus(4'b1000, 1'b1);
    waitValid(3, 9362, "n6_max_valid");
    checkOutput("n6_max_best",  32'(best6), 32'd55);
    checkOutput("n6_max_count", 32'(cnt6),  32'd1);

    // Reset during CALC aborts the run; a clean restart matches a fresh run
    $display("[TB] reset mid-search");
    tableSel = 1'b0;
    applyStimulus(4'b0001, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_valid", 32'(valid4), 32'd0);
    checkOutput("midrst_best",  32'(best4),  32'd0);
    checkOutput("midrst_count", 32'(cnt4),   32'd0);
    checkOutput("midrst_w",     32'(w4),     32'd0);
    checkOutput("midrst_j",     32'(j4),     32'd0);
    RST = 1'b0;
    applyStimulus(4'b0001, 1'b0);
    waitValid(0, 218, "rerun_valid");
    checkOutput("rerun_best",  32'(best4), 32'd4);
    checkOutput("rerun_count", 32'(cnt4),  32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
